flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumer end of the ALU status path: latches the ALU's N/Z/C/V outputs into an architectural NZCV register and evaluates branch conditions against it.
- The zero input is the output of the 64-bit zero-flag detector.
- Sits between EX and the PC-select logic of the ARM-style datapath. Handles B.cond (against stored or forwarded flags) and CBZ/CBNZ (against a separate zero detect of the tested register).
- Produces a registered, one-cycle-latency branch decision.

Parameters:
- FORWARD, 1: when 1, a B.cond presented in the same cycle as set_flags evaluates against the incoming ALU flags; when 0, it evaluates against the stored flags.
- RESET_FLAGS, 4'b0000: NZCV value loaded on reset, bit order {N,Z,C,V}.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_negative  input  1  ALU result bit 63.
- alu_zero  input  1  ALU zero flag, from the zero detector.
- alu_carry_out  input  1  ALU carry out.
- alu_overflow  input  1  ALU signed overflow.
- set_flags  input  1  current instruction is flag-setting (ADDS/SUBS); load NZCV at the clock edge.
- br_valid  input  1  a branch is presented this cycle.
- br_type  input  2  0 = B (unconditional), 1 = B.cond, 2 = CBZ, 3 = CBNZ.
- cond  input  4  ARM condition field; used only for B.cond.
- reg_zero  input  1  zero detect of the CBZ/CBNZ source register.
- flags_q  output  4  stored NZCV {N,Z,C,V}.
- br_done  output  1  registered: a decision is valid this cycle.
- take_branch  output  1  registered: branch taken; meaningful only when br_done = 1.

Behaviour:
- Reset, synchronous, when reset = 1 at a rising edge:
  - flags_q <= RESET_FLAGS; br_done <= 0; take_branch <= 0.
  - set_flags and br_valid in that cycle are ignored.
  - A branch presented in the cycle reset deasserts is processed normally.
- Flag register:
  - If set_flags = 1 and reset = 0 at an edge: flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
  - Otherwise flags_q holds.
- Effective flags F:
  - F = incoming ALU flags when FORWARD = 1, set_flags = 1 and br_type = 1.
  - F = flags_q in every other case.
- Condition evaluation, combinational on F (N, Z, C, V):
  - EQ 0: Z; NE 1: !Z.
  - HS 2: C; LO 3: !C.
  - MI 4: N; PL 5: !N.
  - VS 6: V; VC 7: !V.
  - HI 8: C & !Z; LS 9: !C | Z.
  - GE 10: N == V; LT 11: N != V.
  - GT 12: !Z & (N == V); LE 13: Z | (N != V).
  - AL 14: 1; NV 15: 1 (ARMv8 semantics).
- Decision by br_type: B -> 1; B.cond -> cond_eval(F, cond); CBZ -> reg_zero; CBNZ -> !reg_zero.
- Latency: one cycle.
  - At an edge with br_valid = 1: br_done <= 1; take_branch <= decision.
  - With br_valid = 0: br_done <= 0; take_branch <= 0, so take_branch is never high while br_done is low.
- Back-to-back branches are allowed every cycle, with no stall.
- CBZ/CBNZ never read or modify flags_q, even when set_flags = 1 in the same cycle.
- The flag update and the branch registration occur at the same edge.

Decomposition:
- Shared package flag_pkg contains:
  - enum cond_e, 4 bits, the 16 codes above;
  - enum br_type_e, 2 bits;
  - localparams for the flag bit indices: FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
- One combinational sub-module, cond_eval (inputs nzcv[3:0] and cond[3:0]; output pass). It is reusable by a later conditional-select block.
- The flag register and output registers stay in the top module.

Test Plan:
- Reset: drive reset = 1 for 2 cycles with set_flags = 1 and alu flags 4'b1111 -> flags_q = 4'b0000, br_done = 0, take_branch = 0.
- Flag load and EQ/NE: set_flags = 1 with alu_zero = 1 (others 0) -> next cycle flags_q = 4'b0100. Then B.cond cond = 0 -> take_branch = 1 one cycle later; cond = 1 -> 0.
- Signed compares:
  - load NZCV = 4'b1000 (N = 1, V = 0) -> GE = 0, LT = 1, GT = 0, LE = 1;
  - load 4'b1001 -> GE = 1, GT = 1;
  - sweep all 16 codes against all 16 NZCV values and compare with a reference model.
- Forwarding: flags_q = 4'b0000 while set_flags = 1 with alu_zero = 1 and B.cond EQ in the same cycle -> take_branch = 1 with FORWARD = 1, take_branch = 0 with FORWARD = 0. flags_q = 4'b0100 afterward in both cases.
- CBZ/CBNZ isolation: flags_q = 4'b0100; CBZ with reg_zero = 0 -> take_branch = 0; CBNZ with reg_zero = 0 -> 1; simultaneous set_flags is ignored by the decision.
- Throughput and reset mid-stream:
  - issue branches on 4 consecutive cycles (B, CBZ reg_zero = 1, B.cond AL, CBNZ reg_zero = 1) -> br_done = 1 on 4 consecutive cycles with take_branch = 1, 1, 1, 0;
  - assert reset during the third branch -> br_done = 0 the next cycle.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared types and constants for the flag/branch path: condition codes,
// branch kinds and the bit positions of N, Z, C and V inside an NZCV nibble.
package flag_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    BR_UNCOND = 2'd0,
    BR_COND   = 2'd1,
    BR_CBZ    = 2'd2,
    BR_CBNZ   = 2'd3
  } br_type_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Bundle of ALU status, branch request and branch result signals between
// the EX stage (master) and the flag/branch unit (slave).
interface flag_branch_unit_if;

  logic       alu_negative;
  logic       alu_zero;
  logic       alu_carry_out;
  logic       alu_overflow;
  logic       set_flags;
  logic       br_valid;
  logic [1:0] br_type;
  logic [3:0] cond;
  logic       reg_zero;
  logic [3:0] flags_q;
  logic       br_done;
  logic       take_branch;

  modport master (
    output alu_negative, alu_zero, alu_carry_out, alu_overflow,
    output set_flags, br_valid, br_type, cond, reg_zero,
    input  flags_q, br_done, take_branch
  );

  modport slave (
    input  alu_negative, alu_zero, alu_carry_out, alu_overflow,
    input  set_flags, br_valid, br_type, cond, reg_zero,
    output flags_q, br_done, take_branch
  );

endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Pure combinational ARM condition-code evaluator over an NZCV nibble.
// Kept standalone so a later conditional-select block can reuse it.
module cond_eval
  import flag_pkg::*;
(
  input  logic [3:0] nzcv,
  input  cond_e      cond,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Decode each condition code; NV behaves as always, matching ARMv8.
  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_HS: pass = c;
      COND_LO: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural NZCV register plus a one-cycle registered branch decision
// for B, B.cond, CBZ and CBNZ. B.cond may see the flags being written in
// the same cycle when FORWARD is set.
module flag_branch_unit
  import flag_pkg::*;
#(
  parameter bit         FORWARD     = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  flag_branch_unit_if.slave  bus
);

  logic [3:0] aluFlags;
  logic [3:0] effFlags;
  logic       condPass;
  logic       decision;
  br_type_e   brType;

  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;
  logic       brDone_q;
  logic       brDone_d;
  logic       takeBranch_q;
  logic       takeBranch_d;

  assign aluFlags = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
  assign brType   = br_type_e'(bus.br_type);

  // Pick the flags a B.cond sees: the in-flight ALU flags when forwarding, else the stored ones.
  always_comb begin
    effFlags = nzcv_q;
    if (FORWARD && bus.set_flags && (brType == BR_COND)) begin
      effFlags = aluFlags;
    end
  end

  cond_eval u_cond_eval (
    .nzcv (effFlags),
    .cond (cond_e'(bus.cond)),
    .pass (condPass)
  );

  // Branch outcome by kind; CBZ/CBNZ only look at the register zero detect.
  always_comb begin
    decision = 1'b1;
    case (brType)
      BR_UNCOND: decision = 1'b1;
      BR_COND:   decision = condPass;
      BR_CBZ:    decision = bus.reg_zero;
      BR_CBNZ:   decision = !bus.reg_zero;
      default:   decision = 1'b1;
    endcase
  end

  // Next-state for flags and branch result; take is forced low without a valid branch.
  always_comb begin
    nzcv_d       = nzcv_q;
    brDone_d     = bus.br_valid;
    takeBranch_d = bus.br_valid & decision;
    if (bus.set_flags) begin
      nzcv_d = aluFlags;
    end
  end

  // State registers with synchronous reset that overrides any same-cycle request.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q       <= RESET_FLAGS;
      brDone_q     <= 1'b0;
      takeBranch_q <= 1'b0;
    end else begin
      nzcv_q       <= nzcv_d;
      brDone_q     <= brDone_d;
      takeBranch_q <= takeBranch_d;
    end
  end

  assign bus.flags_q     = nzcv_q;
  assign bus.br_done     = brDone_q;
  assign bus.take_branch = takeBranch_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: two instances (forwarding on and
// off) receive identical stimulus; expected results are queued when a cycle
// is driven and compared just after the following rising edge.
module tb_flag_branch_unit;

  logic clk = 1'b0;
  logic reset;

  flag_branch_unit_if busFwd ();
  flag_branch_unit_if busNoFwd ();

  flag_branch_unit #(.FORWARD(1'b1), .RESET_FLAGS(4'b0000)) dutFwd (
    .clk   (clk),
    .reset (reset),
    .bus   (busFwd.slave)
  );

  flag_branch_unit #(.FORWARD(1'b0), .RESET_FLAGS(4'b0000)) dutNoFwd (
    .clk   (clk),
    .reset (reset),
    .bus   (busNoFwd.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       done;
    logic       takeFwd;
    logic       takeNoFwd;
    logic [3:0] flags;
  } exp_t;

  exp_t sb[$];
  logic [3:0] mdlFlags;
  int testsRun = 0;
  int testsFailed = 0;

  // Reference condition check in ARM pseudocode form: base test then optional inversion.
  function automatic logic refCond(input logic [3:0] f, input logic [3:0] cd);
    logic n, z, c, v, r;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if (cd[0] && cd != 4'hF) r = !r;
    return r;
  endfunction

  function automatic logic refDecision(input logic [3:0] f, input logic [1:0] bt,
                                       input logic [3:0] cd, input logic rz);
    case (bt)
      2'd0: return 1'b1;
      2'd1: return refCond(f, cd);
      2'd2: return rz;
      default: return !rz;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on both instances, queue the expectation, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic rst, input logic sf,
                               input logic [3:0] alu, input logic bv, input logic [1:0] bt,
                               input logic [3:0] cd, input logic rz);
    exp_t e;
    exp_t got;
    logic [3:0] fFwd;
    reset = rst;
    busFwd.set_flags = sf;   busNoFwd.set_flags = sf;
    busFwd.alu_negative = alu[3];  busNoFwd.alu_negative = alu[3];
    busFwd.alu_zero = alu[2];      busNoFwd.alu_zero = alu[2];
    busFwd.alu_carry_out = alu[1]; busNoFwd.alu_carry_out = alu[1];
    busFwd.alu_overflow = alu[0];  busNoFwd.alu_overflow = alu[0];
    busFwd.br_valid = bv;  busNoFwd.br_valid = bv;
    busFwd.br_type = bt;   busNoFwd.br_type = bt;
    busFwd.cond = cd;      busNoFwd.cond = cd;
    busFwd.reg_zero = rz;  busNoFwd.reg_zero = rz;

    fFwd = (sf && bt == 2'd1) ? alu : mdlFlags;
    e.tag       = tag;
    e.done      = rst ? 1'b0 : bv;
    e.takeFwd   = (rst || !bv) ? 1'b0 : refDecision(fFwd, bt, cd, rz);
    e.takeNoFwd = (rst || !bv) ? 1'b0 : refDecision(mdlFlags, bt, cd, rz);
    e.flags     = rst ? 4'b0000 : (sf ? alu : mdlFlags);
    mdlFlags    = e.flags;
    sb.push_back(e);

    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({got.tag, ".done"},      {31'd0, busFwd.br_done},       {31'd0, got.done});
    checkOutput({got.tag, ".take"},      {31'd0, busFwd.take_branch},   {31'd0, got.takeFwd});
    checkOutput({got.tag, ".flags"},     {28'd0, busFwd.flags_q},       {28'd0, got.flags});
    checkOutput({got.tag, ".nf_done"},   {31'd0, busNoFwd.br_done},     {31'd0, got.done});
    checkOutput({got.tag, ".nf_take"},   {31'd0, busNoFwd.take_branch}, {31'd0, got.takeNoFwd});
    checkOutput({got.tag, ".nf_flags"},  {28'd0, busNoFwd.flags_q},     {28'd0, got.flags});
  endtask

  // Watchdog so the run always ends even if the clock stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequences followed by a full condition/flag sweep.
  initial begin
    mdlFlags = 4'b0000;

    applyStimulus("reset0", 1'b1, 1'b1, 4'b1111, 1'b1, 2'd0, 4'd0, 1'b0);
    applyStimulus("reset1", 1'b1, 1'b1, 4'b1111, 1'b1, 2'd0, 4'd0, 1'b0);

    applyStimulus("loadZ",  1'b0, 1'b1, 4'b0100, 1'b0, 2'd0, 4'd0, 1'b0);
    applyStimulus("EQ",     1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd0, 1'b0);
    applyStimulus("NE",     1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd1, 1'b0);

    applyStimulus("loadN",  1'b0, 1'b1, 4'b1000, 1'b0, 2'd0, 4'd0, 1'b0);
    applyStimulus("GE_n",   1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd10, 1'b0);
    applyStimulus("LT_n",   1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd11, 1'b0);
    applyStimulus("GT_n",   1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd12, 1'b0);
    applyStimulus("LE_n",   1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd13, 1'b0);
    applyStimulus("loadNV", 1'b0, 1'b1, 4'b1001, 1'b0, 2'd0, 4'd0, 1'b0);
    applyStimulus("GE_nv",  1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd10, 1'b0);
    applyStimulus("GT_nv",  1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd12, 1'b0);

    for (int f = 0; f < 16; f++) begin
      applyStimulus($sformatf("sweep_ld%0d", f), 1'b0, 1'b1, f[3:0], 1'b0, 2'd0, 4'd0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        applyStimulus($sformatf("sweep_f%0d_c%0d", f, c), 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, c[3:0], 1'b0);
      end
    end

    applyStimulus("fwd_clr", 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0);
    applyStimulus("fwd_EQ",  1'b0, 1'b1, 4'b0100, 1'b1, 2'd1, 4'd0, 1'b0);

    applyStimulus("cbz_rz0",  1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 4'd0, 1'b0);
    applyStimulus("cbnz_rz0", 1'b0, 1'b1, 4'b0100, 1'b1, 2'd3, 4'd0, 1'b0);
    applyStimulus("cbz_rz1",  1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd0, 1'b1);

    applyStimulus("tp_B",    1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 4'd0,  1'b0);
    applyStimulus("tp_CBZ",  1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd0,  1'b1);
    applyStimulus("tp_AL",   1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd14, 1'b0);
    applyStimulus("tp_CBNZ", 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 4'd0,  1'b1);
    applyStimulus("idle",    1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd0,  1'b0);

    applyStimulus("rs_B",    1'b0, 1'b1, 4'b0110, 1'b1, 2'd0, 4'd0,  1'b0);
    applyStimulus("rs_CBZ",  1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 4'd0,  1'b1);
    applyStimulus("rs_AL",   1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 4'd14, 1'b0);
    applyStimulus("rs_CBNZ", 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3, 4'd0,  1'b0);
    applyStimulus("rs_idle", 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 4'd0,  1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
